// File: rtl/ram_timer.sv
// Memory-mapped 32-bit timer that sits beside the data RAM on the CPU bus.
// It has a prescaled up-counter, a compare match with optional auto-reload, and a level interrupt.
module ram_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        irq_o
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic        r_en;
  logic        r_auto_reload;
  logic        r_ie;
  logic        r_match;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [15:0] r_pre;

  logic        w_hit;
  logic        w_rd;
  logic        w_wr;
  logic [1:0]  w_reg;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_match;
  logic        w_unused;

  // Byte-lane merge: lanes with sel[n]=0 keep their current contents.
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] v;
    v = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) v[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return v;
  endfunction

  assign w_hit        = ce && (addr[31:4] == BASE_ADDR[31:4]);
  assign w_rd         = w_hit && !we;
  assign w_wr         = w_hit && we;
  assign w_reg        = addr[3:2];
  assign w_wr_ctrl    = w_wr && (w_reg == REG_CTRL);
  assign w_wr_count   = w_wr && (w_reg == REG_COUNT);
  assign w_wr_compare = w_wr && (w_reg == REG_COMPARE);
  assign w_wr_status  = w_wr && (w_reg == REG_STATUS);
  assign w_unused     = ^addr[1:0];

  assign w_tick  = r_en && (r_pre == PRE_LAST);
  assign w_match = w_tick && (r_count == r_compare);

  assign hit_o = w_hit;
  assign irq_o = r_ie && r_match;

  always_comb begin
    data_o = 32'd0;
    if (rst && w_rd) begin
      case (w_reg)
        REG_CTRL:    data_o = {29'd0, r_ie, r_auto_reload, r_en};
        REG_COUNT:   data_o = r_count;
        REG_COMPARE: data_o = r_compare;
        default:     data_o = {31'd0, r_match};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en          <= 1'b0;
      r_auto_reload <= 1'b0;
      r_ie          <= 1'b0;
      r_match       <= 1'b0;
      r_count       <= 32'd0;
      r_compare     <= 32'hFFFF_FFFF;
      r_pre         <= 16'd0;
    end else begin
      if (!r_en || w_tick) r_pre <= 16'd0;
      else                 r_pre <= r_pre + 16'd1;

      if (w_wr_ctrl && sel[0]) begin
        r_en          <= data_i[0];
        r_auto_reload <= data_i[1];
        r_ie          <= data_i[2];
      end

      // A CPU write to COUNT wins over the tick; the match still sees the old COUNT.
      if (w_wr_count)
        r_count <= f_merge(r_count, data_i, sel);
      else if (w_tick)
        r_count <= (w_match && r_auto_reload) ? 32'd0 : r_count + 32'd1;

      if (w_wr_compare)
        r_compare <= f_merge(r_compare, data_i, sel);

      if (w_match)
        r_match <= 1'b1;
      else if (w_wr_status && sel[0] && data_i[0])
        r_match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_timer.sv
// Bench for ram_timer: two instances (PRESCALE=1 and PRESCALE=4) in adjacent windows.
// Reads queue their expected response; a negedge monitor pops and compares.
module tb_ram_timer;

  localparam logic [31:0] A1 = 32'h1000_0000;
  localparam logic [31:0] A4 = 32'h1000_0010;
  localparam logic [31:0] CTRL = 32'h0;
  localparam logic [31:0] CNT  = 32'h4;
  localparam logic [31:0] CMP  = 32'h8;
  localparam logic [31:0] STAT = 32'hC;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] d1, d4;
  logic        h1, h4, irq1, irq4;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic        irq1;
    logic        irq4;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ram_timer #(.BASE_ADDR(A1), .PRESCALE(1)) u_t1 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(d1), .hit_o(h1), .irq_o(irq1));

  ram_timer #(.BASE_ADDR(A4), .PRESCALE(4)) u_t4 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(d4), .hit_o(h4), .irq_o(irq4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every read cycle presents a response on the bus.
  always @(negedge clk) begin
    if (ce && !we) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: addr=%h data=%h with no expected entry", addr, d1 | d4);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ((d1 | d4) !== e.data || (h1 | h4) !== e.hit || irq1 !== e.irq1 || irq4 !== e.irq4) begin
          n_fail++;
          $display("FAIL %s: got data=%h hit=%b irq1=%b irq4=%b, want data=%h hit=%b irq1=%b irq4=%b",
                   e.name, d1 | d4, h1 | h4, irq1, irq4, e.data, e.hit, e.irq1, e.irq4);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; sel = s; data_i = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] d,
                    input logic h, input logic i1, input logic i4);
    exp_t e;
    e.name = n; e.data = d; e.hit = h; e.irq1 = i1; e.irq4 = i4;
    q.push_back(e);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF; data_i = 32'd0;
    @(posedge clk);
    #1;
    ce = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; data_i = 32'd0;
    idle(3);
    rst = 1'b1;

    // reset values
    rd("rst_ctrl",    A1 + CTRL, 32'h0,         1, 0, 0);
    rd("rst_count",   A1 + CNT,  32'h0,         1, 0, 0);
    rd("rst_compare", A1 + CMP,  32'hFFFF_FFFF, 1, 0, 0);
    rd("rst_status",  A4 + STAT, 32'h0,         1, 0, 0);

    // PRESCALE=1, COMPARE=5, EN|AR|IE: match on 6th edge, reload to 0
    wr(A1 + CMP, 4'hF, 32'd5);
    wr(A1 + CTRL, 4'hF, 32'h7);
    idle(4);
    rd("ar_count4",   A1 + CNT,  32'd4, 1, 0, 0);
    rd("ar_count5",   A1 + CNT,  32'd5, 1, 0, 0);
    rd("ar_reload",   A1 + CNT,  32'd0, 1, 1, 0);
    rd("ar_status",   A1 + STAT, 32'd1, 1, 1, 0);
    wr(A1 + STAT, 4'hF, 32'h1);
    rd("ar_w1c",      A1 + STAT, 32'd0, 1, 0, 0);
    wr(A1 + CTRL, 4'hF, 32'h0);

    // PRESCALE=4, COMPARE=2, EN|IE: match 12 clocks after enable
    wr(A4 + CMP, 4'hF, 32'd2);
    wr(A4 + CTRL, 4'hF, 32'h5);
    idle(10);
    rd("ps_pre10",    A4 + STAT, 32'd0, 1, 0, 0);
    rd("ps_pre11",    A4 + STAT, 32'd0, 1, 0, 0);
    rd("ps_match",    A4 + STAT, 32'd1, 1, 0, 1);
    rd("ps_count3",   A4 + CNT,  32'd3, 1, 0, 1);
    idle(2);
    rd("ps_count4",   A4 + CNT,  32'd4, 1, 0, 1);
    wr(A4 + STAT, 4'hF, 32'h1);
    rd("ps_w1c",      A4 + STAT, 32'd0, 1, 0, 0);

    // wrap through FFFF_FFFF with COMPARE=0
    wr(A1 + CNT, 4'hF, 32'hFFFF_FFFE);
    wr(A1 + CMP, 4'hF, 32'h0);
    wr(A1 + CTRL, 4'hF, 32'h1);
    rd("wrap_fffe",   A1 + CNT,  32'hFFFF_FFFE, 1, 0, 0);
    rd("wrap_ffff",   A1 + CNT,  32'hFFFF_FFFF, 1, 0, 0);
    rd("wrap_nomatch", A1 + STAT, 32'd0, 1, 0, 0);
    rd("wrap_match",  A1 + STAT, 32'd1, 1, 0, 0);
    rd("wrap_cont",   A1 + CNT,  32'd2, 1, 0, 0);
    wr(A1 + CTRL, 4'hF, 32'h0);
    wr(A1 + STAT, 4'hF, 32'h1);

    // byte writes, sel=0, reserved bits, window miss
    wr(A1 + CMP, 4'hF, 32'hFFFF_FFFF);
    wr(A1 + CMP, 4'b0010, 32'h0000_AB00);
    rd("byte_write",  A1 + CMP, 32'hFFFF_ABFF, 1, 0, 0);
    wr(A1 + CMP, 4'b0000, 32'h0);
    wr(32'h2000_0008, 4'hF, 32'h0);
    rd("miss_read",   32'h2000_0008, 32'h0, 0, 0, 0);
    rd("miss_nochg",  A1 + CMP, 32'hFFFF_ABFF, 1, 0, 0);
    wr(A1 + CTRL, 4'hF, 32'hFFFF_FFF8);
    rd("ctrl_rsvd",   A1 + CTRL, 32'h0, 1, 0, 0);

    // same edge: match vs W1C
    wr(A1 + CMP, 4'hF, 32'd2);
    wr(A1 + CNT, 4'hF, 32'd0);
    wr(A1 + CTRL, 4'hF, 32'h1);
    idle(2);
    wr(A1 + STAT, 4'hF, 32'h1);
    rd("match_beats_w1c", A1 + STAT, 32'd1, 1, 0, 0);

    // same edge: COMPARE write, tick uses old COMPARE
    wr(A1 + CTRL, 4'hF, 32'h0);
    wr(A1 + CNT, 4'hF, 32'd0);
    wr(A1 + STAT, 4'hF, 32'h1);
    rd("cmp_clear",   A1 + STAT, 32'd0, 1, 0, 0);
    wr(A1 + CTRL, 4'hF, 32'h1);
    idle(2);
    wr(A1 + CMP, 4'hF, 32'd50);
    rd("cmp_old_match", A1 + STAT, 32'd1, 1, 0, 0);
    rd("cmp_new_val", A1 + CMP, 32'd50, 1, 0, 0);

    // same edge: COUNT write beats tick, match on pre-write COUNT
    wr(A1 + CTRL, 4'hF, 32'h0);
    wr(A1 + CMP, 4'hF, 32'd2);
    wr(A1 + CNT, 4'hF, 32'd0);
    wr(A1 + STAT, 4'hF, 32'h1);
    wr(A1 + CTRL, 4'hF, 32'h1);
    idle(2);
    wr(A1 + CNT, 4'hF, 32'd100);
    rd("cnt_write_wins", A1 + CNT, 32'd100, 1, 0, 0);
    rd("cnt_prewrite_match", A1 + STAT, 32'd1, 1, 0, 0);
    wr(A1 + CTRL, 4'hF, 32'h0);
    wr(A1 + STAT, 4'hF, 32'h1);

    // async reset mid-count with irq asserted
    wr(A1 + CNT, 4'hF, 32'd0);
    wr(A1 + CMP, 4'hF, 32'd2);
    wr(A1 + CTRL, 4'hF, 32'h5);
    idle(5);
    rd("pre_rst_status", A1 + STAT, 32'd1, 1, 1, 0);
    rd("pre_rst_ctrl",   A1 + CTRL, 32'd5, 1, 1, 0);
    rst = 1'b0;
    rd("in_rst_read",    A1 + CNT,  32'd0, 1, 0, 0);
    wr(A1 + CMP, 4'hF, 32'h1234);
    rst = 1'b1;
    rd("post_rst_compare", A1 + CMP,  32'hFFFF_FFFF, 1, 0, 0);
    rd("post_rst_count",   A1 + CNT,  32'd0, 1, 0, 0);
    rd("post_rst_status",  A1 + STAT, 32'd0, 1, 0, 0);
    rd("post_rst_ctrl",    A1 + CTRL, 32'd0, 1, 0, 0);

    idle(2);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
